// File: rtl/tge_cpu_pkt_engine_if.sv
// MAC-side CPU-port streams of the 10GbE CPU packet engine.
// A TX word moves on a cycle with mac_tx_valid && mac_tx_ack. Data and end stay stable until then.
// RX has no backpressure: every mac_rx_valid cycle carries one word.
interface tge_cpu_pkt_engine_if;
  logic [63:0] mac_tx_data;
  logic        mac_tx_valid;
  logic        mac_tx_end;
  logic        mac_tx_ack;
  logic [63:0] mac_rx_data;
  logic        mac_rx_valid;
  logic        mac_rx_end;
  logic        mac_rx_bad;

  modport master (
    output mac_tx_data, mac_tx_valid, mac_tx_end,
    input  mac_tx_ack,
    input  mac_rx_data, mac_rx_valid, mac_rx_end, mac_rx_bad
  );

  modport slave (
    input  mac_tx_data, mac_tx_valid, mac_tx_end,
    output mac_tx_ack,
    output mac_rx_data, mac_rx_valid, mac_rx_end, mac_rx_bad
  );
endinterface

// File: rtl/tge_cpu_pkt_engine.sv
// Fabric-side CPU packet engine: drains the CPU TX buffer to the MAC and fills the CPU RX buffer
// from the MAC. The TX path and the RX path are independent.
module tge_cpu_pkt_engine #(
  parameter int BUF_AWIDTH     = 8,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      cpu_clk,
  input  logic                      cpu_rst_n,
  input  logic [BUF_AWIDTH-1:0]     cpu_tx_size,
  input  logic                      cpu_tx_ready,
  output logic                      cpu_tx_done,
  output logic [BUF_AWIDTH-1:0]     tx_buf_addr,
  input  logic [63:0]               tx_buf_rd_data,
  tge_cpu_pkt_engine_if.master      mac,
  output logic [BUF_AWIDTH-1:0]     rx_buf_addr,
  output logic [63:0]               rx_buf_wr_data,
  output logic                      rx_buf_wr_en,
  output logic [BUF_AWIDTH-1:0]     cpu_rx_size,
  input  logic                      cpu_rx_ack,
  output logic [DROP_CNT_WIDTH-1:0] rx_drop_count,
  output logic                      tx_busy,
  output logic [2:0]                dbg_tx_state,
  output logic [1:0]                dbg_rx_state
);

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_FETCH = 3'd1,
    TX_SEND  = 3'd2,
    TX_DONE  = 3'd3,
    TX_WAIT  = 3'd4
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_FILL    = 2'd1,
    RX_DISCARD = 2'd2,
    RX_FULL    = 2'd3
  } rx_state_e;

  // ---------------------------------------------------------------- TX path
  tx_state_e             tx_state_q;
  logic [BUF_AWIDTH-1:0] tx_size_q;
  logic [BUF_AWIDTH-1:0] tx_idx_q;
  logic [BUF_AWIDTH-1:0] tx_last;
  logic [63:0]           tx_data_q;
  logic                  tx_valid_q;
  logic                  tx_end_q;
  logic                  tx_done_q;

  assign tx_last = tx_size_q - 1'b1;

  // The word index doubles as the buffer read address; the read data is captured in TX_FETCH.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_size_q  <= '0;
      tx_idx_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_end_q   <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (cpu_tx_ready) begin
            tx_size_q <= cpu_tx_size;
            tx_idx_q  <= '0;
            if (cpu_tx_size != '0) begin
              tx_state_q <= TX_FETCH;
            end else begin
              tx_state_q <= TX_DONE;
              tx_done_q  <= 1'b1;
            end
          end
        end
        TX_FETCH: begin
          tx_data_q  <= tx_buf_rd_data;
          tx_valid_q <= 1'b1;
          tx_end_q   <= (tx_idx_q == tx_last);
          tx_state_q <= TX_SEND;
        end
        TX_SEND: begin
          if (mac.mac_tx_ack) begin
            tx_valid_q <= 1'b0;
            tx_end_q   <= 1'b0;
            if (tx_end_q) begin
              tx_state_q <= TX_DONE;
              tx_done_q  <= 1'b1;
            end else begin
              tx_idx_q   <= tx_idx_q + 1'b1;
              tx_state_q <= TX_FETCH;
            end
          end
        end
        TX_DONE: begin
          tx_done_q  <= 1'b0;
          tx_state_q <= TX_WAIT;
        end
        TX_WAIT: begin
          // A request that stays high must not start a second packet.
          if (!cpu_tx_ready) begin
            tx_state_q <= TX_IDLE;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_buf_addr      = tx_idx_q;
  assign mac.mac_tx_data  = tx_data_q;
  assign mac.mac_tx_valid = tx_valid_q;
  assign mac.mac_tx_end   = tx_end_q;
  assign cpu_tx_done      = tx_done_q;
  assign tx_busy          = (tx_state_q != TX_IDLE);
  assign dbg_tx_state     = tx_state_q;

  // ---------------------------------------------------------------- RX path
  rx_state_e                 rx_state_q;
  logic [BUF_AWIDTH-1:0]     rx_count_q;
  logic [BUF_AWIDTH-1:0]     rx_size_q;
  logic [DROP_CNT_WIDTH-1:0] rx_drop_q;
  logic                      rx_in_frame_q;
  logic                      rx_wr;
  logic                      rx_at_limit;
  logic                      rx_open_next;

  // The buffer holds at most 2^BUF_AWIDTH-1 words, so a word arriving at the all-ones count overflows.
  assign rx_at_limit  = &rx_count_q;
  assign rx_open_next = mac.mac_rx_valid ? !mac.mac_rx_end : rx_in_frame_q;

  always_comb begin
    rx_wr = 1'b0;
    case (rx_state_q)
      RX_IDLE: rx_wr = mac.mac_rx_valid && !cpu_rx_ack;
      RX_FILL: rx_wr = mac.mac_rx_valid && !rx_at_limit;
      default: rx_wr = 1'b0;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      rx_state_q    <= RX_IDLE;
      rx_count_q    <= '0;
      rx_size_q     <= '0;
      rx_drop_q     <= '0;
      rx_in_frame_q <= 1'b0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (mac.mac_rx_valid) begin
            if (cpu_rx_ack) begin
              rx_drop_q <= rx_drop_q + 1'b1;
              if (!mac.mac_rx_end) begin
                rx_state_q <= RX_DISCARD;
              end
            end else if (mac.mac_rx_end) begin
              if (mac.mac_rx_bad) begin
                rx_drop_q <= rx_drop_q + 1'b1;
              end else begin
                rx_size_q  <= {{(BUF_AWIDTH-1){1'b0}}, 1'b1};
                rx_count_q <= {{(BUF_AWIDTH-1){1'b0}}, 1'b1};
                rx_state_q <= RX_FULL;
              end
            end else begin
              rx_count_q <= {{(BUF_AWIDTH-1){1'b0}}, 1'b1};
              rx_state_q <= RX_FILL;
            end
          end
        end
        RX_FILL: begin
          if (mac.mac_rx_valid) begin
            if (rx_at_limit) begin
              rx_drop_q  <= rx_drop_q + 1'b1;
              rx_count_q <= '0;
              rx_state_q <= mac.mac_rx_end ? RX_IDLE : RX_DISCARD;
            end else if (mac.mac_rx_end) begin
              if (mac.mac_rx_bad) begin
                rx_drop_q  <= rx_drop_q + 1'b1;
                rx_count_q <= '0;
                rx_state_q <= RX_IDLE;
              end else begin
                rx_size_q  <= rx_count_q + 1'b1;
                rx_count_q <= rx_count_q + 1'b1;
                rx_state_q <= RX_FULL;
              end
            end else begin
              rx_count_q <= rx_count_q + 1'b1;
            end
          end
        end
        RX_DISCARD: begin
          if (mac.mac_rx_valid && mac.mac_rx_end) begin
            rx_state_q <= RX_IDLE;
          end
        end
        RX_FULL: begin
          // Each frame arriving while the buffer is held counts once, at its first word.
          if (mac.mac_rx_valid && !rx_in_frame_q) begin
            rx_drop_q <= rx_drop_q + 1'b1;
          end
          if (cpu_rx_ack) begin
            rx_size_q     <= '0;
            rx_count_q    <= '0;
            rx_in_frame_q <= 1'b0;
            rx_state_q    <= rx_open_next ? RX_DISCARD : RX_IDLE;
          end else begin
            rx_in_frame_q <= rx_open_next;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_buf_wr_en   = rx_wr;
  assign rx_buf_addr    = rx_count_q;
  assign rx_buf_wr_data = rx_wr ? mac.mac_rx_data : 64'd0;
  assign cpu_rx_size    = rx_size_q;
  assign rx_drop_count  = rx_drop_q;
  assign dbg_rx_state   = rx_state_q;

endmodule

// File: tb/tb_tge_cpu_pkt_engine.sv
// Self-checking bench for tge_cpu_pkt_engine: random packets and frames against a frame-level model.
module tb_tge_cpu_pkt_engine;
  localparam int AW = 8;
  localparam int DW = 16;

  // ---------------------------------------------------------------- clock / reset
  logic cpu_clk = 1'b0;
  logic cpu_rst_n = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  logic [AW-1:0] cpu_tx_size;
  logic          cpu_tx_ready;
  logic          cpu_tx_done;
  logic [AW-1:0] tx_buf_addr;
  logic [63:0]   tx_buf_rd_data;
  logic [AW-1:0] rx_buf_addr;
  logic [63:0]   rx_buf_wr_data;
  logic          rx_buf_wr_en;
  logic [AW-1:0] cpu_rx_size;
  logic          cpu_rx_ack;
  logic [DW-1:0] rx_drop_count;
  logic          tx_busy;
  logic [2:0]    dbg_tx_state;
  logic [1:0]    dbg_rx_state;

  tge_cpu_pkt_engine_if mac_if ();

  tge_cpu_pkt_engine #(.BUF_AWIDTH(AW), .DROP_CNT_WIDTH(DW)) dut (
    .cpu_clk        (cpu_clk),
    .cpu_rst_n      (cpu_rst_n),
    .cpu_tx_size    (cpu_tx_size),
    .cpu_tx_ready   (cpu_tx_ready),
    .cpu_tx_done    (cpu_tx_done),
    .tx_buf_addr    (tx_buf_addr),
    .tx_buf_rd_data (tx_buf_rd_data),
    .mac            (mac_if.master),
    .rx_buf_addr    (rx_buf_addr),
    .rx_buf_wr_data (rx_buf_wr_data),
    .rx_buf_wr_en   (rx_buf_wr_en),
    .cpu_rx_size    (cpu_rx_size),
    .cpu_rx_ack     (cpu_rx_ack),
    .rx_drop_count  (rx_drop_count),
    .tx_busy        (tx_busy),
    .dbg_tx_state   (dbg_tx_state),
    .dbg_rx_state   (dbg_rx_state)
  );

  // ---------------------------------------------------------------- buffer models
  logic [63:0] tx_mem [256];
  logic [63:0] rx_mem [256];
  int          wr_cnt = 0;

  assign tx_buf_rd_data = tx_mem[tx_buf_addr];

  always @(posedge cpu_clk) begin
    if (rx_buf_wr_en) begin
      rx_mem[rx_buf_addr] <= rx_buf_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // ---------------------------------------------------------------- checking
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- TX scoreboard
  logic [63:0] exp_q[$];
  int          ack_mode = 0;
  int          bp_cnt = 0;
  int          tx_acc = 0;
  int          done_cnt = 0;
  int          word_cyc = 0;
  logic        hold_v = 1'b0;
  logic [63:0] hold_data = '0;
  logic        gap_chk = 1'b0;

  always @(negedge cpu_clk) begin
    if (cpu_rst_n) begin
      if (gap_chk) begin
        check_eq("tx_gap", mac_if.mac_tx_valid, 1'b0);
        gap_chk = 1'b0;
      end
      if (cpu_tx_done) done_cnt++;
      if (mac_if.mac_tx_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("tx_extra_word", 1, 0);
        end else begin
          if (hold_v) check_eq("tx_stable", mac_if.mac_tx_data, hold_data);
          word_cyc++;
          if (mac_if.mac_tx_ack) begin
            check_eq("tx_data", mac_if.mac_tx_data, exp_q[0]);
            check_eq("tx_end", mac_if.mac_tx_end, exp_q.size() == 1);
            if (ack_mode == 0) check_eq("tx_one_cycle", word_cyc, 1);
            if (ack_mode == 2 && tx_acc == 1) check_eq("tx_bp_cycles", word_cyc, 6);
            void'(exp_q.pop_front());
            tx_acc++;
            word_cyc = 0;
            hold_v = 1'b0;
            gap_chk = 1'b1;
          end else begin
            hold_v = 1'b1;
            hold_data = mac_if.mac_tx_data;
          end
        end
      end
    end
  end

  // MAC acceptance: 0 always, 1 random, 2 withhold five cycles on the second word.
  initial begin
    mac_if.mac_tx_ack = 1'b0;
    forever begin
      @(posedge cpu_clk);
      #1;
      case (ack_mode)
        1: mac_if.mac_tx_ack = 1'($urandom_range(0, 1));
        2: begin
          if (mac_if.mac_tx_valid && tx_acc == 1 && bp_cnt < 5) begin
            mac_if.mac_tx_ack = 1'b0;
            bp_cnt++;
          end else begin
            mac_if.mac_tx_ack = 1'b1;
          end
        end
        default: mac_if.mac_tx_ack = 1'b1;
      endcase
    end
  end

  task automatic tx_packet(input int size, input int mode);
    int n;
    int budget;
    exp_q.delete();
    for (int i = 0; i < size; i++) begin
      tx_mem[i] = {$urandom, $urandom};
      exp_q.push_back(tx_mem[i]);
    end
    ack_mode = mode;
    bp_cnt = 0;
    tx_acc = 0;
    done_cnt = 0;
    word_cyc = 0;
    hold_v = 1'b0;
    cpu_tx_size = AW'(size);
    cpu_tx_ready = 1'b1;
    budget = 20 * size + 50;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge cpu_clk);
      n++;
      if (n == 1 && mode == 1) begin
        #1 cpu_tx_size = AW'($urandom_range(0, 255));
      end
    end
    #1;
    if (done_cnt == 0) check_eq("tx_done_timeout", n, 0);
    if (size == 0) check_eq("tx_zero_latency", n <= 2, 1);
    repeat (6) @(posedge cpu_clk);
    #1;
    check_eq("tx_done_pulses", done_cnt, 1);
    check_eq("tx_words", tx_acc, size);
    check_eq("tx_busy_wait", tx_busy, 1'b1);
    cpu_tx_ready = 1'b0;
    repeat (2) @(posedge cpu_clk);
    #1;
    check_eq("tx_busy_idle", tx_busy, 1'b0);
  endtask

  // ---------------------------------------------------------------- RX model and driver
  int m_held = 0;
  int m_drop = 0;

  task automatic rx_frame(input int len, input logic bad, input logic with_ack, input logic gaps);
    logic [63:0] words[$];
    int exp_w;
    int w0;
    w0 = wr_cnt;
    if (with_ack) begin
      exp_w = 0; m_drop++; m_held = 0;
    end else if (m_held != 0) begin
      exp_w = 0; m_drop++;
    end else if (len > 255) begin
      exp_w = 255; m_drop++;
    end else if (bad) begin
      exp_w = len; m_drop++;
    end else begin
      exp_w = len; m_held = len;
    end
    cpu_rx_ack = with_ack;
    for (int i = 0; i < len; i++) begin
      mac_if.mac_rx_valid = 1'b1;
      mac_if.mac_rx_data  = {$urandom, $urandom};
      words.push_back(mac_if.mac_rx_data);
      mac_if.mac_rx_end   = (i == len - 1);
      mac_if.mac_rx_bad   = bad && (i == len - 1);
      @(posedge cpu_clk);
      #1;
      if (gaps && i < len - 1 && $urandom_range(0, 3) == 0) begin
        mac_if.mac_rx_valid = 1'b0;
        mac_if.mac_rx_end   = 1'b0;
        mac_if.mac_rx_bad   = 1'b0;
        @(posedge cpu_clk);
        #1;
      end
    end
    mac_if.mac_rx_valid = 1'b0;
    mac_if.mac_rx_end   = 1'b0;
    mac_if.mac_rx_bad   = 1'b0;
    cpu_rx_ack = 1'b0;
    repeat (2) @(posedge cpu_clk);
    #1;
    check_eq("rx_writes", wr_cnt - w0, exp_w);
    check_eq("rx_size", cpu_rx_size, m_held);
    check_eq("rx_drops", rx_drop_count, DW'(m_drop));
    for (int i = 0; i < exp_w; i++) check_eq("rx_mem", rx_mem[i], words[i]);
  endtask

  task automatic rx_release();
    cpu_rx_ack = 1'b1;
    repeat (2) @(posedge cpu_clk);
    #1;
    m_held = 0;
    check_eq("rx_size_after_ack", cpu_rx_size, 0);
    cpu_rx_ack = 1'b0;
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_tx_valid"}, mac_if.mac_tx_valid, 0);
    check_eq({tag, "_tx_end"}, mac_if.mac_tx_end, 0);
    check_eq({tag, "_tx_data"}, mac_if.mac_tx_data, 0);
    check_eq({tag, "_tx_done"}, cpu_tx_done, 0);
    check_eq({tag, "_tx_addr"}, tx_buf_addr, 0);
    check_eq({tag, "_tx_busy"}, tx_busy, 0);
    check_eq({tag, "_rx_wr_en"}, rx_buf_wr_en, 0);
    check_eq({tag, "_rx_addr"}, rx_buf_addr, 0);
    check_eq({tag, "_rx_size"}, cpu_rx_size, 0);
    check_eq({tag, "_rx_drop"}, rx_drop_count, 0);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "bench timed out");
  end

  // ---------------------------------------------------------------- main sequence
  initial begin
    cpu_tx_size = '0;
    cpu_tx_ready = 1'b0;
    cpu_rx_ack = 1'b0;
    mac_if.mac_rx_valid = 1'b0;
    mac_if.mac_rx_data  = '0;
    mac_if.mac_rx_end   = 1'b0;
    mac_if.mac_rx_bad   = 1'b0;
    for (int i = 0; i < 256; i++) tx_mem[i] = '0;
    repeat (3) @(posedge cpu_clk);
    #1;
    check_all_zero("reset");
    cpu_rst_n = 1'b1;
    @(posedge cpu_clk);
    #1;

    // TX: basic packets, restart after ready drops, backpressure, empty packet, random acks
    tx_packet(3, 0);
    tx_packet(3, 0);
    tx_packet(4, 2);
    tx_packet(0, 0);
    tx_packet(1, 0);
    for (int k = 0; k < 4; k++) tx_packet($urandom_range(1, 20), 1);

    // RX: good frame, frame while held, release, bad frame, ack on first word
    rx_frame(4, 1'b0, 1'b0, 1'b0);
    rx_frame(3, 1'b0, 1'b0, 1'b0);
    rx_release();
    rx_frame(5, 1'b1, 1'b0, 1'b1);
    rx_frame(3, 1'b0, 1'b1, 1'b0);
    rx_frame(1, 1'b1, 1'b0, 1'b0);
    rx_frame(1, 1'b0, 1'b0, 1'b0);
    rx_frame(4, 1'b0, 1'b1, 1'b0);
    rx_frame(2, 1'b0, 1'b0, 1'b0);
    rx_release();

    // RX overflow and largest accepted frame
    rx_frame(256, 1'b0, 1'b0, 1'b0);
    rx_frame(255, 1'b0, 1'b0, 1'b0);
    rx_release();

    for (int k = 0; k < 6; k++) begin
      rx_frame($urandom_range(1, 30), $urandom_range(0, 3) == 0, 1'b0, 1'b1);
      if ($urandom_range(0, 1) == 1) rx_release();
    end
    rx_release();

    // TX and RX together
    for (int k = 0; k < 3; k++) begin
      fork
        tx_packet($urandom_range(1, 12), 1);
        rx_frame($urandom_range(1, 12), 1'b0, 1'b0, 1'b1);
      join
      rx_release();
    end

    // Reset in the middle of a TX packet
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      tx_mem[i] = {$urandom, $urandom};
      exp_q.push_back(tx_mem[i]);
    end
    ack_mode = 0; tx_acc = 0; done_cnt = 0; word_cyc = 0; hold_v = 1'b0;
    cpu_tx_size = AW'(10);
    cpu_tx_ready = 1'b1;
    repeat (7) @(posedge cpu_clk);
    #3;
    cpu_rst_n = 1'b0;
    cpu_tx_ready = 1'b0;
    #1;
    check_all_zero("rst_tx");
    exp_q.delete();
    gap_chk = 1'b0; hold_v = 1'b0; word_cyc = 0;
    m_held = 0; m_drop = 0;
    @(posedge cpu_clk);
    #3 cpu_rst_n = 1'b1;
    @(posedge cpu_clk);
    #1;
    tx_packet(5, 0);

    // Reset in the middle of an RX frame while the buffer is held
    rx_frame(3, 1'b0, 1'b0, 1'b0);
    mac_if.mac_rx_valid = 1'b1;
    mac_if.mac_rx_data  = 64'h1234;
    repeat (2) @(posedge cpu_clk);
    #3;
    cpu_rst_n = 1'b0;
    mac_if.mac_rx_valid = 1'b0;
    #1;
    check_all_zero("rst_rx");
    m_held = 0; m_drop = 0;
    @(posedge cpu_clk);
    #3 cpu_rst_n = 1'b1;
    @(posedge cpu_clk);
    #1;
    rx_frame(6, 1'b0, 1'b0, 1'b0);
    rx_release();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
